// File: rtl/chunked_adder_ctrl.sv
// Wide adder sequencer: feeds one BIT_WIDTH chunk per clock to an external
// narrow adder, chains the carry through a register and holds the wide result.
module chunked_adder_ctrl #(
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BIT_WIDTH*NUM_CHUNKS-1:0] a_in,
  input  logic [BIT_WIDTH*NUM_CHUNKS-1:0] b_in,
  input  logic                            carry_in,
  output logic [BIT_WIDTH-1:0]            add_a,
  output logic [BIT_WIDTH-1:0]            add_b,
  output logic                            add_cin,
  input  logic [BIT_WIDTH-1:0]            add_sum,
  input  logic                            add_cout,
  output logic                            busy,
  output logic                            done,
  output logic [BIT_WIDTH*NUM_CHUNKS-1:0] result,
  output logic                            overflow
);

  localparam int W     = BIT_WIDTH * NUM_CHUNKS;
  localparam int IDX_W = $clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [W-1:0]       a_reg, b_reg;
  logic [W-1:0]       result_reg;
  logic               overflow_reg;

  logic [BIT_WIDTH-1:0] a_chunk [NUM_CHUNKS];
  logic [BIT_WIDTH-1:0] b_chunk [NUM_CHUNKS];

  // Chunk views of the latched operands, selected by idx_reg while running.
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
    assign a_chunk[gi] = a_reg[gi*BIT_WIDTH +: BIT_WIDTH];
    assign b_chunk[gi] = b_reg[gi*BIT_WIDTH +: BIT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        add_a   = a_chunk[idx_reg];
        add_b   = b_chunk[idx_reg];
        add_cin = carry_reg;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg        <= a_in;
            b_reg        <= b_in;
            carry_reg    <= carry_in;
            idx_reg      <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
          end
        end
        RUN: begin
          result_reg[idx_reg*BIT_WIDTH +: BIT_WIDTH] <= add_sum;
          carry_reg <= add_cout;
          // The last chunk's carry-out is the wide overflow; idx is not advanced past it.
          if (idx_reg == LAST_IDX) begin
            overflow_reg <= add_cout;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign result   = result_reg;
  assign overflow = overflow_reg;

endmodule
